// File: rtl/draw_scheduler_pkg.sv
// Shared constants and state encoding for the frame draw sequencer.
// Sprite size here is also used by the collision checker.
package draw_scheduler_pkg;

  localparam int SPRITE_BITS  = 4;
  localparam int CNT_W        = 2 * SPRITE_BITS;
  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int CLEAR_PIXELS = SCREEN_W * SCREEN_H;

  localparam logic [2:0] BG_COLOUR  = 3'b000;
  localparam logic [2:0] PLR_COLOUR = 3'b100;
  localparam logic [2:0] OBS_COLOUR = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR_ALL,
    S_CLR_PLR,
    S_DRW_PLR,
    S_CLR_OBS,
    S_DRW_OBS,
    S_DONE
  } state_t;

endpackage

// File: rtl/draw_scheduler_sprite_raster.sv
// Maps a sprite base position and pixel index to a screen coordinate.
// Sums are 9 bits wide so sprites hanging off the right/bottom edge are clipped, not wrapped.
module draw_scheduler_sprite_raster
  import draw_scheduler_pkg::*;
(
  input  logic [7:0]       i_base_x,
  input  logic [7:0]       i_base_y,
  input  logic [CNT_W-1:0] i_cnt,
  output logic [8:0]       o_px,
  output logic [8:0]       o_py,
  output logic             o_in_bounds
);

  always_comb begin
    o_px        = {1'b0, i_base_x} + 9'(i_cnt[SPRITE_BITS-1:0]);
    o_py        = {1'b0, i_base_y} + 9'(i_cnt[CNT_W-1:SPRITE_BITS]);
    o_in_bounds = (o_px < 9'(SCREEN_W)) && (o_py < 9'(SCREEN_H));
  end

endmodule

// File: rtl/draw_scheduler.sv
// Shares the VGA plot port between full-screen clear and per-frame sprite erase/redraw.
// Outputs are registered from the current state, so pixel k of a pass appears k+1 cycles after acceptance.
module draw_scheduler
  import draw_scheduler_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_frame_tick,
  input  logic       i_clear_req,
  input  logic [7:0] i_player_x,
  input  logic [7:0] i_player_y,
  input  logic [7:0] i_obstacle_x,
  input  logic [7:0] i_obstacle_y,
  output logic [7:0] o_x,
  output logic [7:0] o_y,
  output logic [2:0] o_colour,
  output logic       o_plot,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_overrun
);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [14:0]      r_clr_cnt;
  logic [7:0]       r_clr_x, r_clr_y;
  logic [7:0]       r_new_px, r_new_py, r_new_ox, r_new_oy;
  logic [7:0]       r_prev_px, r_prev_py, r_prev_ox, r_prev_oy;
  logic             r_prev_valid, r_clear_pass;
  logic [7:0]       r_x, r_y;
  logic [2:0]       r_colour;
  logic             r_plot, r_busy, r_frame_done, r_overrun;

  logic [7:0]       w_base_x, w_base_y;
  logic [2:0]       w_colour;
  logic             w_sprite, w_cnt_last, w_clr_last;
  logic [8:0]       w_px, w_py;
  logic             w_in_bounds;

  draw_scheduler_sprite_raster u_raster (
    .i_base_x    (w_base_x),
    .i_base_y    (w_base_y),
    .i_cnt       (r_cnt),
    .o_px        (w_px),
    .o_py        (w_py),
    .o_in_bounds (w_in_bounds)
  );

  always_comb begin
    w_next     = r_state;
    w_base_x   = r_new_px;
    w_base_y   = r_new_py;
    w_colour   = BG_COLOUR;
    w_sprite   = 1'b0;
    w_cnt_last = &r_cnt;
    w_clr_last = (r_clr_cnt == 15'(CLEAR_PIXELS - 1));
    case (r_state)
      S_IDLE: begin
        if (i_clear_req)       w_next = S_CLEAR_ALL;
        else if (i_frame_tick) w_next = r_prev_valid ? S_CLR_PLR : S_DRW_PLR;
      end
      S_CLEAR_ALL: if (w_clr_last) w_next = S_DONE;
      S_CLR_PLR: begin
        w_sprite = 1'b1;
        w_base_x = r_prev_px;
        w_base_y = r_prev_py;
        if (w_cnt_last) w_next = S_DRW_PLR;
      end
      S_DRW_PLR: begin
        w_sprite = 1'b1;
        w_colour = PLR_COLOUR;
        if (w_cnt_last) w_next = r_prev_valid ? S_CLR_OBS : S_DRW_OBS;
      end
      S_CLR_OBS: begin
        w_sprite = 1'b1;
        w_base_x = r_prev_ox;
        w_base_y = r_prev_oy;
        if (w_cnt_last) w_next = S_DRW_OBS;
      end
      S_DRW_OBS: begin
        w_sprite = 1'b1;
        w_base_x = r_new_ox;
        w_base_y = r_new_oy;
        w_colour = OBS_COLOUR;
        if (w_cnt_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_clr_cnt    <= '0;
      r_clr_x      <= '0;
      r_clr_y      <= '0;
      r_prev_valid <= 1'b0;
      r_clear_pass <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_colour     <= BG_COLOUR;
      r_plot       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        r_cnt     <= '0;
        r_clr_cnt <= '0;
        r_clr_x   <= '0;
        r_clr_y   <= '0;
        if (i_clear_req) begin
          r_clear_pass <= 1'b1;
        end else if (i_frame_tick) begin
          r_clear_pass <= 1'b0;
          r_new_px     <= i_player_x;
          r_new_py     <= i_player_y;
          r_new_ox     <= i_obstacle_x;
          r_new_oy     <= i_obstacle_y;
        end
      end else if (i_frame_tick) begin
        r_overrun <= 1'b1;
      end
      if (w_sprite) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_CLEAR_ALL) begin
        r_clr_cnt <= r_clr_cnt + 15'd1;
        if (r_clr_x == 8'(SCREEN_W - 1)) begin
          r_clr_x <= '0;
          r_clr_y <= r_clr_y + 8'd1;
        end else begin
          r_clr_x <= r_clr_x + 8'd1;
        end
        if (w_clr_last) r_prev_valid <= 1'b0;
      end
      if (r_state == S_DONE && !r_clear_pass) begin
        r_prev_px    <= r_new_px;
        r_prev_py    <= r_new_py;
        r_prev_ox    <= r_new_ox;
        r_prev_oy    <= r_new_oy;
        r_prev_valid <= 1'b1;
      end
      if (r_state == S_CLEAR_ALL) begin
        r_x      <= r_clr_x;
        r_y      <= r_clr_y;
        r_colour <= BG_COLOUR;
      end else if (w_sprite) begin
        r_x      <= w_px[7:0];
        r_y      <= w_py[7:0];
        r_colour <= w_colour;
      end
      r_plot       <= (w_sprite && w_in_bounds) || (r_state == S_CLEAR_ALL);
      r_busy       <= (r_state != S_IDLE);
      r_frame_done <= (r_state == S_DONE);
    end
  end

  assign o_x          = r_x;
  assign o_y          = r_y;
  assign o_colour     = r_colour;
  assign o_plot       = r_plot;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_overrun    = r_overrun;

endmodule
